// File: rtl/multiplier_shift_add.sv
// Sequential signed 32x16 multiplier: sign-magnitude shift-and-add over 16 RUN cycles,
// then one FIX cycle that restores the sign and forms the fixed-point Scaled result.
module multiplier_shift_add #(
  parameter int FRAC = 16
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] Multiplicand,
  input  logic [15:0] Multiplier,
  output logic [47:0] Product,
  output logic [31:0] Scaled,
  output logic        Overflow,
  output logic        Busy,
  output logic        Finish
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] mag_a;
  logic [15:0] mag_b;
  logic        neg;
  logic [47:0] acc;
  logic [3:0]  count;

  logic [31:0]        abs_a;
  logic [15:0]        abs_b;
  logic [47:0]        partial;
  logic [47:0]        acc_next;
  logic [47:0]        signed_prod;
  logic signed [47:0] shifted;
  logic               scaled_ovf;

  // Magnitudes are kept unsigned so 0x80000000 and 0x8000 map to 2^31 and 2^15 exactly.
  assign abs_a = Multiplicand[31] ? (~Multiplicand + 32'd1) : Multiplicand;
  assign abs_b = Multiplier[15]   ? (~Multiplier + 16'd1)   : Multiplier;

  assign partial  = {16'd0, mag_a} << count;
  assign acc_next = acc + (mag_b[count] ? partial : 48'd0);

  assign signed_prod = neg ? (~acc + 48'd1) : acc;
  assign shifted     = $signed(signed_prod) >>> FRAC;
  // Truncation is lossless only when bits 47..31 are all copies of the new sign bit.
  assign scaled_ovf  = !((&shifted[47:31]) || !(|shifted[47:31]));

  // NOTE: all state is written with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      mag_a    <= '0;
      mag_b    <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      count    <= '0;
      Product  <= '0;
      Scaled   <= '0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Finish   <= 1'b0;
    end else if (START) begin
      // A START in any state, including mid-operation, restarts from fresh operands.
      mag_a  <= abs_a;
      mag_b  <= abs_b;
      neg    <= Multiplicand[31] ^ Multiplier[15];
      acc    <= '0;
      count  <= '0;
      Finish <= 1'b0;
      Busy   <= 1'b1;
      state  <= RUN;
    end else begin
      case (state)
        RUN: begin
          acc   <= acc_next;
          count <= count + 4'd1;
          if (count == 4'd15) state <= FIX;
        end
        FIX: begin
          Product  <= signed_prod;
          Scaled   <= shifted[31:0];
          Overflow <= scaled_ovf;
          Finish   <= 1'b1;
          Busy     <= 1'b0;
          state    <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_shift_add.sv
// Self-checking bench: directed and random multiplies against an arithmetic reference,
// on two instances (FRAC=16 and FRAC=0) sharing the same stimulus.
module tb_multiplier_shift_add;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [31:0] Multiplicand;
  logic [15:0] Multiplier;

  logic [47:0] product16, product0;
  logic [31:0] scaled16, scaled0;
  logic        ovf16, ovf0, busy16, busy0, finish16, finish0;

  int checks   = 0;
  int failures = 0;

  logic [47:0] prev_p;

  always #5 CLOCK = ~CLOCK;

  multiplier_shift_add #(.FRAC(16)) dut16 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Product(product16), .Scaled(scaled16), .Overflow(ovf16),
    .Busy(busy16), .Finish(finish16)
  );

  multiplier_shift_add #(.FRAC(0)) dut0 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Product(product0), .Scaled(scaled0), .Overflow(ovf0),
    .Busy(busy0), .Finish(finish0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ref_product(input logic [31:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[47:0];
  endfunction

  function automatic longint ref_shift(input logic [47:0] p, input int frac);
    longint s;
    s = longint'($signed(p));
    return s >>> frac;
  endfunction

  function automatic logic [31:0] ref_scaled(input logic [47:0] p, input int frac);
    longint s;
    s = ref_shift(p, frac);
    return s[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [47:0] p, input int frac);
    longint s;
    s = ref_shift(p, frac);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(negedge CLOCK);
  endtask

  // Full operation: START at edge 0, busy window over edges 1..16, result at edge 17.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input string tag);
    logic [47:0] ep;
    bit bad;
    Multiplicand = a;
    Multiplier   = b;
    START        = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_start"}, 64'({busy16, finish16, busy0, finish0}), 64'(4'b1010));
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      Multiplicand = $urandom;
      Multiplier   = 16'($urandom);
      tick();
      if (busy16 !== 1'b1 || finish16 !== 1'b0 || busy0 !== 1'b1 || finish0 !== 1'b0 ||
          product16 !== prev_p || product0 !== prev_p)
        bad = 1'b1;
    end
    check({tag, "_window"}, 64'(bad), 64'(0));
    tick();
    ep = ref_product(a, b);
    check({tag, "_fin16"},  64'({finish16, busy16}), 64'(2'b10));
    check({tag, "_prod16"}, 64'(product16), 64'(ep));
    check({tag, "_scl16"},  64'(scaled16),  64'(ref_scaled(ep, 16)));
    check({tag, "_ovf16"},  64'(ovf16),     64'(ref_ovf(ep, 16)));
    check({tag, "_fin0"},   64'({finish0, busy0}), 64'(2'b10));
    check({tag, "_prod0"},  64'(product0),  64'(ep));
    check({tag, "_scl0"},   64'(scaled0),   64'(ref_scaled(ep, 0)));
    check({tag, "_ovf0"},   64'(ovf0),      64'(ref_ovf(ep, 0)));
    prev_p = ep;
  endtask

  initial begin
    bit bad;
    RESET_N      = 1'b0;
    START        = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    prev_p       = '0;

    // Reset state, and START held during reset must not launch anything.
    tick();
    START = 1'b1;
    Multiplicand = 32'd5;
    Multiplier   = 16'd5;
    tick();
    tick();
    check("reset_outs16", 64'({product16, scaled16, ovf16, busy16, finish16}), 64'(0));
    check("reset_outs0",  64'({product0, scaled0, ovf0, busy0, finish0}), 64'(0));
    START   = 1'b0;
    RESET_N = 1'b1;
    tick();
    check("post_reset_idle", 64'({busy16, finish16}), 64'(0));

    run_op(32'd3, 16'd5, "a3b5");
    check("a3b5_const", 64'({product16, scaled16, ovf16}), 64'({48'd15, 32'd0, 1'b0}));

    run_op(-32'sd7, 16'd3, "am7b3");
    check("am7b3_const", 64'(product16), 64'(48'hFFFF_FFFF_FFEB));

    run_op(32'h8000_0000, 16'h8000, "minmin");
    check("minmin_const", 64'(product16), 64'(48'h4000_0000_0000));
    check("minmin_ovf_frac0", 64'(ovf0), 64'(1));

    run_op(32'h8000_0000, 16'h7FFF, "minmax");
    run_op(32'h7FFF_FFFF, 16'h8000, "maxmin");
    run_op(32'd0, 16'h8000, "zero_a");
    run_op(32'h8000_0000, 16'd0, "zero_b");

    run_op(32'h0001_8000, 16'd2, "fix15");
    check("fix15_const", 64'({product16, scaled16, ovf16}),
          64'({48'h0000_0003_0000, 32'h0000_0003, 1'b0}));

    // Restart at edge 8: result must come 17 edges after the second START.
    Multiplicand = 32'd9;
    Multiplier   = 16'd9;
    START        = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    run_op(32'd2, 16'd4, "restart");
    check("restart_const", 64'(product16), 64'(48'd8));

    // Idle after Finish with wiggling operands: outputs stay put.
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      Multiplicand = $urandom;
      Multiplier   = 16'($urandom);
      tick();
      if (product16 !== 48'd8 || finish16 !== 1'b1 || busy16 !== 1'b0 || scaled16 !== 32'd0)
        bad = 1'b1;
    end
    check("idle_stable", 64'(bad), 64'(0));

    // Asynchronous reset midway through a run, checked before any clock edge.
    Multiplicand = 32'h1234_5678;
    Multiplier   = 16'h0F0F;
    START        = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst16", 64'({product16, scaled16, ovf16, busy16, finish16}), 64'(0));
    check("async_rst0",  64'({product0, scaled0, ovf0, busy0, finish0}), 64'(0));
    tick();
    RESET_N = 1'b1;
    prev_p  = '0;
    run_op(32'hFFFF_FF00, 16'h1234, "after_rst");

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra;
      logic [15:0] rb;
      ra = $urandom;
      rb = 16'($urandom);
      if (n % 5 == 0) ra = {ra[31], 31'($urandom_range(0, 255))};
      run_op(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
